// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Owns the tag and valid arrays for a 32-line x 128-bit data array. It detects hits,
// stalls the core on misses and writes, and fills whole blocks from main memory.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   mem_read/write    core requests, held stable while stall=1
//   addr              core word address {tag, index, word_loc}
//   mem_ready         main memory done (block read data valid / word write accepted)
//   stall, hit        core stall and same-cycle read hit
//   cache_we, wsource data-array write enable and source (1 = memory block, 0 = core word)
//   index, word_loc   data-array line address and word select
//   mm_rd_en/wr_en    main-memory block read / word write requests
//   mm_addr           main-memory address
//   hit_count/miss_count  saturating read hit and miss counters
module cache_controller #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned INDEX_W     = 5,
  parameter int unsigned OFFSET_W    = 2,
  parameter int unsigned CACHE_DEPTH = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                mem_ready,
  output logic                stall,
  output logic                hit,
  output logic                cache_we,
  output logic                wsource,
  output logic [INDEX_W-1:0]  index,
  output logic [OFFSET_W-1:0] word_loc,
  output logic                mm_rd_en,
  output logic                mm_wr_en,
  output logic [ADDR_W-1:0]   mm_addr,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrMem} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [CACHE_DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;
  logic [TAG_W-1:0]       tag_mem [CACHE_DEPTH];

  logic [TAG_W-1:0]    req_tag, lat_tag;
  logic [INDEX_W-1:0]  req_idx, lat_idx;
  logic [OFFSET_W-1:0] req_off, lat_off;
  logic                match, fill;

  assign req_tag = addr[ADDR_W-1 -: TAG_W];
  assign req_idx = addr[OFFSET_W +: INDEX_W];
  assign req_off = addr[OFFSET_W-1:0];
  assign lat_tag = addr_q[ADDR_W-1 -: TAG_W];
  assign lat_idx = addr_q[OFFSET_W +: INDEX_W];
  assign lat_off = addr_q[OFFSET_W-1:0];

  assign match = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill  = (state_q == StRdMiss) && mem_ready;

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stall      = 1'b0;
    hit        = 1'b0;
    cache_we   = 1'b0;
    wsource    = 1'b0;
    mm_rd_en   = 1'b0;
    mm_wr_en   = 1'b0;
    mm_addr    = '0;
    index      = lat_idx;
    word_loc   = lat_off;

    unique case (state_q)
      StIdle: begin
        index    = req_idx;
        word_loc = req_off;
        if (mem_write) begin
          // Write-through: update the array only on a hit, never allocate.
          stall    = 1'b1;
          cache_we = match;
          addr_d   = addr;
          state_d  = StWrMem;
        end else if (mem_read) begin
          if (match) begin
            hit = 1'b1;
            if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            stall   = 1'b1;
            addr_d  = addr;
            state_d = StRdMiss;
            if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      StRdMiss: begin
        stall    = 1'b1;
        mm_rd_en = 1'b1;
        mm_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (mem_ready) begin
          cache_we         = 1'b1;
          wsource          = 1'b1;
          valid_d[lat_idx] = 1'b1;
          state_d          = StIdle;
        end
      end
      StWrMem: begin
        // Releasing stall in the ready cycle lets the core advance at this edge.
        mm_wr_en = 1'b1;
        mm_addr  = addr_q;
        stall    = ~mem_ready;
        if (mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs drop as soon as reset asserts, not at the next edge.
    if (rst) begin
      stall    = 1'b0;
      hit      = 1'b0;
      cache_we = 1'b0;
      wsource  = 1'b0;
      mm_rd_en = 1'b0;
      mm_wr_en = 1'b0;
      mm_addr  = '0;
      index    = '0;
      word_loc = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tags are qualified by valid bits, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (fill) tag_mem[lat_idx] <= lat_tag;
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, mem_ready;
  logic [9:0]  addr;
  logic        stall, hit, cache_we, wsource, mm_rd_en, mm_wr_en;
  logic [4:0]  index;
  logic [1:0]  word_loc;
  logic [9:0]  mm_addr;
  logic [15:0] hit_count, miss_count;

  cache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .hit        (hit),
    .cache_we   (cache_we),
    .wsource    (wsource),
    .index      (index),
    .word_loc   (word_loc),
    .mm_rd_en   (mm_rd_en),
    .mm_wr_en   (mm_wr_en),
    .mm_addr    (mm_addr),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_cnt;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_hit, m_miss;

  // Expected output vector: {stall, hit, cache_we, wsource, mm_rd_en, mm_wr_en, mm_addr, index, word_loc}
  task automatic exp_o(input string t, input logic st, input logic h, input logic we,
                       input logic ws, input logic rd, input logic wr, input logic [9:0] ma,
                       input logic [4:0] ix, input logic [1:0] wl);
    exp_t e;
    e.tag    = t;
    e.is_cnt = 1'b0;
    e.val    = {9'd0, st, h, we, ws, rd, wr, ma, ix, wl};
    sb.push_back(e);
  endtask

  task automatic check_now(input string t);
    exp_t        e;
    logic [31:0] obs;
    e.tag    = {t, "_cnt"};
    e.is_cnt = 1'b1;
    e.val    = {m_hit, m_miss};
    sb.push_back(e);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_cnt) obs = {hit_count, miss_count};
      else obs = {9'd0, stall, hit, cache_we, wsource, mm_rd_en, mm_wr_en, mm_addr, index,
                  word_loc};
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
    total++;
    assert ((mm_rd_en & mm_wr_en) === 1'b0) else begin
      bad++;
      $error("FAIL %s_excl observed rd=%b wr=%b expected not both", t, mm_rd_en, mm_wr_en);
    end
  endtask

  task automatic step(input string t);
    @(negedge clk);
    check_now(t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a write pending: outputs must stay low.
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_ready = 1'b1; addr = 10'h085;
    m_hit = '0; m_miss = '0;
    #2;
    exp_o("rst_out", 0, 0, 0, 0, 0, 0, 10'h000, 5'd0, 2'd0); step("rst");
    rst = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
    exp_o("idle", 0, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("idle");

    // Cold read miss, ready on the third RD_MISS cycle
    mem_read = 1'b1;
    exp_o("t1_miss", 1, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t1_miss"); m_miss++;
    exp_o("t1_wait1", 1, 0, 0, 0, 1, 0, 10'h084, 5'd1, 2'd1); step("t1_wait1");
    exp_o("t1_wait2", 1, 0, 0, 0, 1, 0, 10'h084, 5'd1, 2'd1); step("t1_wait2");
    mem_ready = 1'b1;
    exp_o("t1_fill", 1, 0, 1, 1, 1, 0, 10'h084, 5'd1, 2'd1); step("t1_fill");
    mem_ready = 1'b0;
    exp_o("t1_hit", 0, 1, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t1_hit"); m_hit++;

    // Read hit, same block
    addr = 10'h086;
    exp_o("t2_hit", 0, 1, 0, 0, 0, 0, 10'h000, 5'd1, 2'd2); step("t2_hit"); m_hit++;

    // Write hit
    mem_read = 1'b0; mem_write = 1'b1; addr = 10'h087;
    exp_o("t3_wr", 1, 0, 1, 0, 0, 0, 10'h000, 5'd1, 2'd3); step("t3_wr");
    exp_o("t3_wait", 1, 0, 0, 0, 0, 1, 10'h087, 5'd1, 2'd3); step("t3_wait");
    mem_ready = 1'b1;
    exp_o("t3_done", 0, 0, 0, 0, 0, 1, 10'h087, 5'd1, 2'd3); step("t3_done");

    // Write miss, no allocate
    mem_ready = 1'b0; addr = 10'h185;
    exp_o("t4_wr", 1, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t4_wr");
    mem_ready = 1'b1;
    exp_o("t4_done", 0, 0, 0, 0, 0, 1, 10'h185, 5'd1, 2'd1); step("t4_done");
    mem_ready = 1'b0; mem_write = 1'b0; mem_read = 1'b1; addr = 10'h085;
    exp_o("t4_rd_hit", 0, 1, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t4_rd_hit"); m_hit++;

    // Conflict replacement in line 1
    addr = 10'h185;
    exp_o("t5a_miss", 1, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t5a_miss"); m_miss++;
    mem_ready = 1'b1;
    exp_o("t5a_fill", 1, 0, 1, 1, 1, 0, 10'h184, 5'd1, 2'd1); step("t5a_fill");
    mem_ready = 1'b0;
    exp_o("t5a_hit", 0, 1, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t5a_hit"); m_hit++;
    addr = 10'h085;
    exp_o("t5b_miss", 1, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t5b_miss"); m_miss++;
    mem_ready = 1'b1;
    exp_o("t5b_fill", 1, 0, 1, 1, 1, 0, 10'h084, 5'd1, 2'd1); step("t5b_fill");
    mem_ready = 1'b0;
    exp_o("t5b_hit", 0, 1, 0, 0, 0, 0, 10'h000, 5'd1, 2'd1); step("t5b_hit"); m_hit++;

    // Reset in the middle of a miss
    addr = 10'h206;
    exp_o("t6_miss", 1, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd2); step("t6_miss"); m_miss++;
    exp_o("t6_wait", 1, 0, 0, 0, 1, 0, 10'h204, 5'd1, 2'd2); step("t6_wait");
    #2 rst = 1'b1;
    #1;
    m_hit = '0; m_miss = '0;
    exp_o("t6_async", 0, 0, 0, 0, 0, 0, 10'h000, 5'd0, 2'd0); check_now("t6_async");
    addr = 10'h086;
    exp_o("t6_in_rst", 0, 0, 0, 0, 0, 0, 10'h000, 5'd0, 2'd0); step("t6_in_rst");
    rst = 1'b0;
    exp_o("t6_remiss", 1, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd2); step("t6_remiss"); m_miss++;
    mem_ready = 1'b1;
    exp_o("t6_fill", 1, 0, 1, 1, 1, 0, 10'h084, 5'd1, 2'd2); step("t6_fill");
    mem_ready = 1'b0;
    exp_o("t6_hit", 0, 1, 0, 0, 0, 0, 10'h000, 5'd1, 2'd2); step("t6_hit"); m_hit++;

    // Miss counter saturation
    mem_read = 1'b0;
    force dut.miss_cnt_q = 16'hFFFF;
    #1;
    release dut.miss_cnt_q;
    m_miss = 16'hFFFF;
    mem_read = 1'b1; addr = 10'h306;
    exp_o("sat_miss", 1, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd2); step("sat_miss");
    exp_o("sat_hold", 1, 0, 0, 0, 1, 0, 10'h304, 5'd1, 2'd2); step("sat_hold");
    mem_ready = 1'b1;
    exp_o("sat_fill", 1, 0, 1, 1, 1, 0, 10'h304, 5'd1, 2'd2); step("sat_fill");
    mem_ready = 1'b0; mem_read = 1'b0;
    exp_o("end_idle", 0, 0, 0, 0, 0, 0, 10'h000, 5'd1, 2'd2); step("end_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Direct-mapped cache controller that sequences the 32-line x 128-bit cache data array for the RISC core. It holds the tag and valid arrays, detects hits and misses, and stalls the core. It fills whole blocks from main memory on read misses and uses a write-through, no-write-allocate policy, with a request/ready handshake to main memory. It also keeps saturating read hit and miss counters for performance measurement.

Parameters:
ADDR_W, 10, word address width from the core; tag width TAG_W = ADDR_W - INDEX_W - OFFSET_W (3 at defaults)
INDEX_W, 5, line index width
OFFSET_W, 2, word-in-block offset width (4 x 32-bit words per 128-bit block)
CACHE_DEPTH, 32, number of lines, equal to 2**INDEX_W
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  core read request, held stable while stall=1
mem_write  in  1  core write request, held stable while stall=1
addr  in  ADDR_W  core word address: [1:0] word_loc, [6:2] index, [9:7] tag
mem_ready  in  1  main memory done: block read data valid, or word write accepted
stall  out  1  freezes the core
hit  out  1  read hit this cycle (combinational)
cache_we  out  1  write enable to the data array
wsource  out  1  data-array write source: 1 = main-memory block, 0 = core word
index  out  INDEX_W  data-array line address
word_loc  out  OFFSET_W  data-array word select
mm_rd_en  out  1  main-memory block read request
mm_wr_en  out  1  main-memory word write request
mm_addr  out  ADDR_W  main-memory address
hit_count  out  CNT_W  saturating count of read hits
miss_count  out  CNT_W  saturating count of read misses

Behaviour:
- States: IDLE, RD_MISS, WR_MEM. Reset state is IDLE.
- Reset (async, rst=1): state=IDLE; all valid bits=0; counters=0; latched address=0. The tag array is not reset. All outputs drop immediately.
- Reset output values: stall=0, hit=0, cache_we=0, wsource=0, mm_rd_en=0, mm_wr_en=0, mm_addr=0, index=0, word_loc=0.
- match = valid[addr index] & (tag[addr index] == addr tag).
- index and word_loc: in IDLE they come from addr; in other states they come from the address latched on leaving IDLE.
- IDLE, mem_write=1 (takes priority if mem_read=1 in the same cycle):
  - stall=1.
  - If match: cache_we=1, wsource=0, the word is updated at this edge.
  - If no match: no cache write (no allocate).
  - Latch addr; go to WR_MEM.
- IDLE, mem_read=1, match:
  - hit=1, stall=0; stay in IDLE.
  - Data is read from the array combinationally in the same cycle.
  - hit_count increments.
- IDLE, mem_read=1, no match:
  - stall=1; latch addr; go to RD_MISS.
  - miss_count increments.
- IDLE, no request: all request and enable outputs 0; stall=0.
- RD_MISS:
  - stall=1, mm_rd_en=1, mm_addr = {latched tag, latched index, 2'b00}.
  - On mem_ready=1: cache_we=1 and wsource=1 in the same cycle; at the edge tag[index] = latched tag and valid[index]=1; go to IDLE.
  - The next cycle re-evaluates the held request as a hit, so stall=0 and hit_count increments.
  - Miss penalty: (cycles until mem_ready) + 1.
- WR_MEM:
  - mm_wr_en=1, mm_addr = latched full address; core inputs are ignored.
  - stall=1 while mem_ready=0.
  - In the cycle mem_ready=1: stall=0, so the core advances at that edge; go to IDLE.
- mem_ready is ignored in IDLE.
- mm_rd_en and mm_wr_en are never both 1.
- Counters saturate at all-ones and do not wrap.
- A new request is accepted only in IDLE.
- A reset mid-RD_MISS or mid-WR_MEM aborts the transaction. No tag or valid update occurs.

Test Plan:
1. Cold read miss:
   - Stimulus: after reset, read addr=0x085; mem_ready=1 on the 3rd RD_MISS cycle.
   - Response: stall=1; mm_rd_en=1 with mm_addr=0x084; cache_we=1, wsource=1, index=1 in the ready cycle.
   - Next cycle: hit=1, stall=0, word_loc=1, miss_count=1, hit_count=1.
2. Read hit, same block:
   - Stimulus: read 0x086.
   - Response: hit=1, stall=0 in the same cycle; no mm request; word_loc=2; hit_count=2.
3. Write hit:
   - Stimulus: write 0x087.
   - Response, first cycle: cache_we=1, wsource=0, index=1, word_loc=3, stall=1.
   - Then: mm_wr_en=1 with mm_addr=0x087 until mem_ready; stall=0 in the ready cycle; back to IDLE.
4. Write miss, no allocate:
   - Stimulus: write 0x185 (tag 3, index 1).
   - Response: cache_we=0; mm write only.
   - Follow-up: read 0x085 is still a hit; counters unchanged except hit_count+1.
5. Conflict replacement:
   - Stimulus: read 0x185, then read 0x085.
   - Response: 0x185 misses and fills tag 3 into line 1 (mm_addr=0x184); 0x085 then misses (mm_addr=0x084); miss_count increases by 2.
6. Reset mid-miss:
   - Stimulus: assert rst during RD_MISS.
   - Response: mm_rd_en and stall drop asynchronously; counters=0.
   - Follow-up: read 0x086 after reset misses.
   - Saturation: force miss_count to 0xFFFF; a further miss holds it at 0xFFFF.
